// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared pixel width, frame size and state/grant encodings for the frame-buffer arbiter
package vga_fb_pkg;
  localparam int PIX_W = 3;
  localparam int FRAME_PIX_DEF = 307200;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_e;
  typedef enum logic [1:0] {G_NONE, G_FETCH, G_WRITE, G_WRITE_STARVED} grant_e;
endpackage

// File: rtl/vga_fb_fifo.sv
// vga_fb_fifo: pixel prefetch FIFO with flush and first-word-fall-through head (0 when empty)
module vga_fb_fifo #(
  parameter int W = 3,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic take;
  always_comb begin
    empty = count == '0;
    take = pop && !empty;
    head = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= take ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(take);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wp] <= din;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one frame-buffer RAM port between display prefetch and coprocessor writes
// Optional VGA_FB_ARB_STATS_EN adds saturating underflow_cnt / wr_stall_cnt outputs.
module vga_fb_arbiter import vga_fb_pkg::*; #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = PIX_W,
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]       underflow_cnt,
  output logic [15:0]       wr_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_e state, state_n;
  grant_e grant;
  logic [ADDR_W-1:0] fetch_addr;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] count;
  logic [CW:0] level;
  logic rd_a, rd_b, empty, fetch_ok, starved, last_pix;
  vga_fb_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(frame_start),
    .push(rd_b),
    .pop(pix_rd),
    .din(mem_rdata),
    .head(pix_data),
    .count(count),
    .empty(empty)
  );
  // rd_a: address on the RAM this cycle; rd_b: its data arrives this cycle
  always_comb begin
    level = (CW+1)'(count) + (CW+1)'(rd_a) + (CW+1)'(rd_b);
    fetch_ok = state == S_FETCH && !frame_start && level < (CW+1)'(FIFO_DEPTH);
    starved = wr_valid && wait_cnt >= WW'(MAX_WAIT) && count >= CW'(LOW_WM);
    grant = starved ? G_WRITE_STARVED : fetch_ok ? G_FETCH : wr_valid ? G_WRITE : G_NONE;
    wr_ready = grant == G_WRITE || grant == G_WRITE_STARVED;
    last_pix = fetch_addr == ADDR_W'(FRAME_PIX - 1);
    state_n = frame_start ? S_FETCH : (grant == G_FETCH && last_pix) ? S_DONE : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      fetch_addr <= '0;
      rd_a <= 1'b0;
      rd_b <= 1'b0;
      wait_cnt <= '0;
      underflow <= 1'b0;
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      rd_a <= grant == G_FETCH;
      rd_b <= rd_a && !frame_start;
      fetch_addr <= frame_start ? '0 : grant == G_FETCH ? fetch_addr + 1'b1 : fetch_addr;
      wait_cnt <= (!wr_valid || wr_ready) ? '0 : wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
      underflow <= frame_start ? 1'b0 : underflow | (pix_rd & empty);
      mem_we <= wr_ready;
      if (grant != G_NONE) mem_addr <= wr_ready ? wr_addr : fetch_addr;
      if (wr_ready) mem_wdata <= wr_data;
    end
`ifdef VGA_FB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      underflow_cnt <= '0;
      wr_stall_cnt <= '0;
    end else begin
      if (pix_rd && empty && underflow_cnt != 16'hffff) underflow_cnt <= underflow_cnt + 1'b1;
      if (wr_valid && !wr_ready && wr_stall_cnt != 16'hffff) wr_stall_cnt <= wr_stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter with a 1-cycle-latency RAM model
module tb_vga_fb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_start = 1'b0, pix_rd = 1'b0, wr_valid = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [2:0] wr_data = '0;
  logic [2:0] pix_data, mem_wdata, mem_rdata;
  logic underflow, wr_ready, mem_we;
  logic [18:0] mem_addr;
  int checks = 0, failures = 0;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_rd(pix_rd),
    .pix_data(pix_data), .underflow(underflow), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem_addr[2:0];

  initial begin
    #200us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [18:0] prev;
    int exp_a, nchg, ng, first_g, last_g, cyc;
    logic r, found;
    repeat (3) @(negedge clk);
    chk("rst_pix_data", 32'(pix_data), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    reset = 1'b1;
    // idle write: same-cycle ready, registered RAM write next cycle
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 19'd5; wr_data = 3'b101;
    #1 chk("idle_wr_ready", 32'(wr_ready), 1);
    @(negedge clk);
    chk("idle_mem_we", 32'(mem_we), 1);
    chk("idle_mem_addr", 32'(mem_addr), 5);
    chk("idle_mem_wdata", 32'(mem_wdata), 5);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("idle_mem_we_off", 32'(mem_we), 0);
    // prefetch fills exactly FIFO_DEPTH entries
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    prev = mem_addr; exp_a = 0; nchg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_addr != prev) begin
        chk("fetch_seq", 32'(mem_addr), 32'(exp_a));
        exp_a++; nchg++; prev = mem_addr;
      end
    end
    chk("fetch_count", 32'(nchg), 16);
    chk("fetch_last", 32'(mem_addr), 15);
    chk("full_head", 32'(pix_data), 0);
    chk("full_mem_we", 32'(mem_we), 0);
    // continuous pop with continuous refill
    for (int i = 0; i < 640; i++) begin
      chk("pop_seq", 32'(pix_data), 32'(i % 8));
      pix_rd = 1'b1;
      @(negedge clk);
    end
    chk("pop_no_underflow", 32'(underflow), 0);
    // starvation: write wins after MAX_WAIT cycles of losing to fetches
    wr_valid = 1'b1; wr_addr = 19'd9; wr_data = 3'd3;
    ng = 0; first_g = -1; last_g = -1;
    for (int c = 0; c < 30; c++) begin
      #1 r = wr_ready;
      @(negedge clk);
      if (r) begin
        chk("starve_mem_we", 32'(mem_we), 1);
        chk("starve_mem_addr", 32'(mem_addr), 9);
        if (ng == 0) first_g = c;
        else chk("starve_gap", 32'(c - last_g), 9);
        last_g = c; ng++;
      end
    end
    wr_valid = 1'b0;
    chk("starve_first", 32'(first_g), 8);
    chk("starve_grants", 32'(ng), 3);
    // pop from an empty FIFO right after frame_start
    frame_start = 1'b1; pix_rd = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("flush_head", 32'(pix_data), 0);
    chk("flush_underflow", 32'(underflow), 0);
    pix_rd = 1'b1;
    @(negedge clk);
    chk("underflow_set", 32'(underflow), 1);
    chk("empty_head", 32'(pix_data), 0);
    // frame_start while address 100 is on the RAM
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (mem_addr == 19'd100) begin
        found = 1'b1;
        break;
      end
    end
    chk("addr100_seen", 32'(found), 1);
    chk("underflow_sticky", 32'(underflow), 1);
    frame_start = 1'b1; pix_rd = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("inflight_flush_head", 32'(pix_data), 0);
    chk("underflow_clr", 32'(underflow), 0);
    @(negedge clk);
    chk("restart_addr", 32'(mem_addr), 0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("restart_data", 32'(pix_data), 32'(i));
      pix_rd = 1'b1;
      @(negedge clk);
    end
    pix_rd = 1'b0;
    cyc = 0;
    chk("restart_underflow", 32'(underflow), 32'(cyc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between VGA scan-out (pixel prefetch into an internal FIFO) and coprocessor pixel writes.
- Display reads are real-time and have priority; writes are served in free slots, with bounded starvation protection.
- Sits between the VGA timing/colour output stage and the frame-buffer RAM. Runs on the pixel clock domain.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 3, pixel width ({r,g,b}).
- FRAME_PIX, 307200, pixels per frame (640x480); fetch addresses 0..FRAME_PIX-1.
- FIFO_DEPTH, 16, prefetch FIFO entries (power of 2).
- LOW_WM, 4, FIFO level at or above which a starved write may pre-empt a fetch.
- MAX_WAIT, 8, cycles a pending write may wait before it becomes starved.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical sync; restarts fetching at address 0.
- pix_rd  in  1  display pops one pixel (asserted only in the active region).
- pix_data  out  DATA_W  pixel at FIFO head; 0 when FIFO empty.
- underflow  out  1  sticky; set when pix_rd hits an empty FIFO, cleared by frame_start.
- wr_valid  in  1  coprocessor write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle (transfer = wr_valid & wr_ready).
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the read address.

Behaviour:
- Reset: state IDLE, FIFO empty, fetch_addr=0, in-flight flag 0, wait_cnt=0; pix_data=0, underflow=0, wr_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
- States: IDLE (no frame yet) -> FETCH on frame_start; FETCH -> DONE when fetch_addr issues FRAME_PIX-1; DONE -> FETCH on frame_start. frame_start in any state: FIFO flushed, fetch_addr=0, in-flight read dropped, underflow cleared, enter FETCH.
- Fetch eligible: state FETCH and (fifo_count + inflight) < FIFO_DEPTH.
- Per-cycle grant (combinational, registered to mem_* ports): starved write (wr_valid & wait_cnt>=MAX_WAIT & fifo_count>=LOW_WM) > fetch eligible > wr_valid > idle. Writes get full bandwidth in IDLE and DONE.
- wr_ready asserted in the same cycle the write is granted; mem_we/mem_addr/mem_wdata driven from registers the following cycle (1-cycle write latency).
- wait_cnt increments each cycle wr_valid is high and not granted, saturates at MAX_WAIT, clears on a write transfer or when wr_valid is low.
- Read: fetch grant drives mem_addr=fetch_addr next cycle; mem_rdata pushed into FIFO one cycle later (2 cycles grant->push). fetch_addr increments per grant.
- A read in flight when frame_start arrives is discarded: no push.
- Simultaneous push and pop: count unchanged. Pop on empty: no change, pix_data=0, underflow set. Push never occurs on full (guaranteed by eligibility).

Optional Feature:
- VGA_FB_ARB_STATS_EN. Defined: adds output underflow_cnt (16 bits, saturating) counting underflowing pops, and output wr_stall_cnt (16 bits, saturating) counting wr_valid & !wr_ready cycles. Both clear on reset only. Undefined: ports absent, no counters.

Decomposition:
- Package vga_fb_pkg: pixel width, FRAME_PIX, state enum (IDLE/FETCH/DONE), grant enum (NONE/FETCH/WRITE/WRITE_STARVED).
- Sub-module vga_fb_fifo: synchronous FIFO with push/pop/flush, count, first-word-fall-through head output.

Test Plan:
- Reset released, no frame_start, wr_valid=1 at addr 5 data 3'b101 -> wr_ready=1 same cycle, mem_we=1 mem_addr=5 mem_wdata=5 next cycle.
- frame_start, no pix_rd, RAM returns addr[2:0] -> exactly 16 reads (addr 0..15), FIFO full, fetching stops; pix_data=0 at head.
- FIFO full, pix_rd held 1 for 640 cycles -> pix_data sequence addr 0..639 mod 8, no underflow, one refill read per pop.
- Continuous fetch demand plus wr_valid held with FIFO level >=4 -> write granted within 9 cycles of request; wr_ready pulses once per 9 cycles max.
- pix_rd on empty FIFO after frame_start -> pix_data=0, underflow=1 until next frame_start, then 0.
- frame_start pulsed while a read is in flight at addr 100 -> returned data not pushed; next read addr 0; FIFO count 0 one cycle after pulse.
